// File: rtl/multicycle_control_if.sv
// Handshake and datapath-control bundle between the multi-cycle controller,
// the instruction/data memories and the datapath.
interface multicycle_control_if #(
   parameter int CNT_W = 32
);
   logic [31:0]      imem_rdata;
   logic             imem_ready;
   logic             dmem_ready;
   logic             alu_zero;
   logic             alu_lt;
   logic             alu_ltu;
   logic             imem_req;
   logic             dmem_req;
   logic             dmem_we;
   logic [31:0]      ir;
   logic [2:0]       alu_op;
   logic [1:0]       alu_src_a;
   logic [1:0]       alu_src_b;
   logic             reg_write;
   logic [1:0]       wb_sel;
   logic             pc_write;
   logic [1:0]       pc_src;
   logic             trap;
   logic [1:0]       trap_cause;
   logic [CNT_W-1:0] instret;

   modport master (
      input  imem_rdata, imem_ready, dmem_ready, alu_zero, alu_lt, alu_ltu,
      output imem_req, dmem_req, dmem_we, ir, alu_op, alu_src_a, alu_src_b,
             reg_write, wb_sel, pc_write, pc_src, trap, trap_cause, instret
   );

   modport slave (
      output imem_rdata, imem_ready, dmem_ready, alu_zero, alu_lt, alu_ltu,
      input  imem_req, dmem_req, dmem_we, ir, alu_op, alu_src_a, alu_src_b,
             reg_write, wb_sel, pc_write, pc_src, trap, trap_cause, instret
   );
endinterface

// File: rtl/multicycle_control.sv
// RV32I multi-cycle control unit: FETCH/DECODE/EXEC/MEM/WB sequencing with
// memory handshakes, wait-state timeout, sticky trap and retired-instruction count.
module multicycle_control #(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 32
) (
   input  logic                 CLK,
   input  logic                 RST,
   multicycle_control_if.master bus
);
   localparam int            TW      = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_L     = 7'b0000011;
   localparam logic [6:0] OP_S     = 7'b0100011;
   localparam logic [6:0] OP_B     = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
   } state_t;

   state_t           state_q, state_d;
   logic [31:0]      ir_q, ir_d;
   logic [TW-1:0]    cnt_q, cnt_d;
   logic [1:0]       cause_q, cause_d;
   logic [CNT_W-1:0] instret_q, instret_d;

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic       legal;
   logic       taken;
   logic       br_bad;

   assign opcode = ir_q[6:0];
   assign funct3 = ir_q[14:12];

   always_comb begin
      legal = 1'b0;
      case (opcode)
         OP_R, OP_I, OP_L, OP_S, OP_B, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: legal = 1'b1;
         default: legal = 1'b0;
      endcase
   end

   always_comb begin
      taken  = 1'b0;
      br_bad = 1'b0;
      case (funct3)
         3'b000:  taken = bus.alu_zero;
         3'b001:  taken = !bus.alu_zero;
         3'b100:  taken = bus.alu_lt;
         3'b101:  taken = !bus.alu_lt;
         3'b110:  taken = bus.alu_ltu;
         3'b111:  taken = !bus.alu_ltu;
         default: br_bad = 1'b1;
      endcase
   end

   // Outputs decode from state and ir; only branch EXEC and store completion look at inputs.
   always_comb begin
      bus.imem_req  = 1'b0;
      bus.dmem_req  = 1'b0;
      bus.dmem_we   = 1'b0;
      bus.alu_op    = 3'b000;
      bus.alu_src_a = 2'b00;
      bus.alu_src_b = 2'b00;
      bus.reg_write = 1'b0;
      bus.wb_sel    = 2'b00;
      bus.pc_write  = 1'b0;
      bus.pc_src    = 2'b00;
      bus.trap      = 1'b0;
      case (state_q)
         S_FETCH: bus.imem_req = 1'b1;
         S_EXEC: begin
            case (opcode)
               OP_R: bus.alu_op = 3'b000;
               OP_I: begin
                  bus.alu_op    = 3'b001;
                  bus.alu_src_b = 2'b01;
               end
               OP_L, OP_S, OP_JALR: begin
                  bus.alu_op    = 3'b010;
                  bus.alu_src_b = 2'b01;
               end
               OP_AUIPC: begin
                  bus.alu_op    = 3'b010;
                  bus.alu_src_a = 2'b01;
                  bus.alu_src_b = 2'b01;
               end
               OP_B: begin
                  bus.alu_op = 3'b100;
                  if (!br_bad) begin
                     bus.pc_write = 1'b1;
                     bus.pc_src   = taken ? 2'b01 : 2'b00;
                  end
               end
               default: ;
            endcase
         end
         S_MEM: begin
            bus.dmem_req = 1'b1;
            bus.dmem_we  = (opcode == OP_S);
            bus.pc_write = (opcode == OP_S) && bus.dmem_ready;
         end
         S_WB: begin
            bus.reg_write = 1'b1;
            bus.pc_write  = 1'b1;
            case (opcode)
               OP_L:             bus.wb_sel = 2'b01;
               OP_JAL, OP_JALR:  bus.wb_sel = 2'b10;
               OP_LUI:           bus.wb_sel = 2'b11;
               default:          bus.wb_sel = 2'b00;
            endcase
            case (opcode)
               OP_JAL:  bus.pc_src = 2'b01;
               OP_JALR: bus.pc_src = 2'b10;
               default: bus.pc_src = 2'b00;
            endcase
         end
         S_TRAP: bus.trap = 1'b1;
         default: ;
      endcase
   end

   assign bus.ir         = ir_q;
   assign bus.trap_cause = cause_q;
   assign bus.instret    = instret_q;

   always_comb begin
      state_d   = state_q;
      ir_d      = ir_q;
      cnt_d     = cnt_q;
      cause_d   = cause_q;
      instret_d = instret_q + CNT_W'(bus.pc_write);
      case (state_q)
         S_IDLE: begin
            state_d = S_FETCH;
            cnt_d   = '0;
         end
         S_FETCH: begin
            if (bus.imem_ready) begin
               ir_d    = bus.imem_rdata;
               state_d = S_DECODE;
            end else begin
               cnt_d = cnt_q + TW'(1);
               if (cnt_q == TO_LAST) begin
                  state_d = S_TRAP;
                  cause_d = 2'b10;
               end
            end
         end
         S_DECODE: begin
            if (legal) state_d = S_EXEC;
            else begin
               state_d = S_TRAP;
               cause_d = 2'b01;
            end
         end
         S_EXEC: begin
            case (opcode)
               OP_B: begin
                  if (br_bad) begin
                     state_d = S_TRAP;
                     cause_d = 2'b01;
                  end else begin
                     state_d = S_FETCH;
                     cnt_d   = '0;
                  end
               end
               OP_L, OP_S: begin
                  state_d = S_MEM;
                  cnt_d   = '0;
               end
               default: state_d = S_WB;
            endcase
         end
         S_MEM: begin
            if (bus.dmem_ready) begin
               cnt_d   = '0;
               state_d = (opcode == OP_S) ? S_FETCH : S_WB;
            end else begin
               cnt_d = cnt_q + TW'(1);
               if (cnt_q == TO_LAST) begin
                  state_d = S_TRAP;
                  cause_d = 2'b11;
               end
            end
         end
         S_WB: begin
            state_d = S_FETCH;
            cnt_d   = '0;
         end
         S_TRAP: state_d = S_TRAP;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q   <= S_IDLE;
         ir_q      <= '0;
         cnt_q     <= '0;
         cause_q   <= 2'b00;
         instret_q <= '0;
      end else begin
         state_q   <= state_d;
         ir_q      <= ir_d;
         cnt_q     <= cnt_d;
         cause_q   <= cause_d;
         instret_q <= instret_d;
      end
   end
endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: vector table with a retire scoreboard, plus
// hand sequences for traps, timeouts and mid-instruction reset.
module tb_multicycle_control;
   localparam int TIMEOUT = 4;
   localparam int CNT_W   = 4;

   logic CLK = 1'b0;
   logic RST = 1'b1;
   always #5 CLK = ~CLK;

   multicycle_control_if #(.CNT_W(CNT_W)) bus ();
   multicycle_control #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
      .CLK(CLK), .RST(RST), .bus(bus)
   );

   typedef struct {
      logic [31:0] instr;
      logic [2:0]  flg;   // {zero, lt, ltu}
      int          iwait;
      int          dwait;
      int          cyc;
      logic        rw;
      logic [1:0]  wb;
      logic [1:0]  pcs;
      int          ndreq;
      logic        we;
      logic [2:0]  op;
      logic [1:0]  sa;
      logic [1:0]  sb;
   } vec_t;

   typedef struct {
      int          cyc;
      logic        rw;
      logic [1:0]  wb;
      logic [1:0]  pcs;
      int          ndreq;
      logic        we;
      logic [31:0] ir;
   } exp_t;

   vec_t vecs[$];
   exp_t sbq[$];
   int checks   = 0;
   int failures = 0;
   logic [CNT_W-1:0] m_instret;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge CLK);
      RST = 1'b1;
      bus.imem_ready = 1'b0;
      bus.dmem_ready = 1'b0;
      {bus.alu_zero, bus.alu_lt, bus.alu_ltu} = 3'b000;
      #1;
      chk("reset_outs", 32'({bus.imem_req, bus.dmem_req, bus.dmem_we, bus.reg_write, bus.pc_write,
                             bus.trap, bus.trap_cause, bus.wb_sel, bus.pc_src, bus.alu_op,
                             bus.alu_src_a, bus.alu_src_b}), 32'd0);
      chk("reset_ir", bus.ir, 32'd0);
      chk("reset_instret", 32'(bus.instret), 32'd0);
      m_instret = '0;
      @(negedge CLK);
      RST = 1'b0;
      #1;
      chk("idle_no_req", 32'(bus.imem_req), 32'd0);
      @(negedge CLK);
      #1;
      chk("first_req", 32'(bus.imem_req), 32'd1);
   endtask

   // Called with the DUT in FETCH; returns at a falling edge with the DUT back in FETCH.
   task automatic run_vec(input vec_t v);
      exp_t e, x;
      int   cyc = 0, iw = 0, dw = 0, nd = 0;
      bit   done = 1'b0;
      logic lwe = 1'b0;
      e = '{v.cyc, v.rw, v.wb, v.pcs, v.ndreq, v.we, v.instr};
      sbq.push_back(e);
      bus.imem_rdata = v.instr;
      {bus.alu_zero, bus.alu_lt, bus.alu_ltu} = v.flg;
      for (int k = 0; k < 40 && !done; k++) begin
         bus.imem_ready = bus.imem_req && (iw == v.iwait);
         bus.dmem_ready = bus.dmem_req && (dw == v.dwait);
         if (bus.imem_req && !bus.imem_ready) iw++;
         if (bus.dmem_req && !bus.dmem_ready) dw++;
         #1;
         if (cyc > 0 || bus.imem_req) cyc++;
         if (bus.dmem_req) begin
            nd++;
            lwe = bus.dmem_we;
         end
         if (cyc == v.iwait + 3)
            chk("exec_alu", 32'({bus.alu_op, bus.alu_src_a, bus.alu_src_b}), 32'({v.op, v.sa, v.sb}));
         if (bus.trap) begin
            chk("unexpected_trap", 32'(bus.trap), 32'd0);
            done = 1'b1;
         end else if (bus.pc_write) begin
            done = 1'b1;
            if (sbq.size() == 0) chk("sb_underflow", 32'd0, 32'd1);
            else begin
               x = sbq.pop_front();
               chk("latency", 32'(cyc), 32'(x.cyc));
               chk("reg_write", 32'(bus.reg_write), 32'(x.rw));
               chk("wb_sel", 32'(bus.wb_sel), 32'(x.wb));
               chk("pc_src", 32'(bus.pc_src), 32'(x.pcs));
               chk("dmem_req_cycles", 32'(nd), 32'(x.ndreq));
               chk("ir", bus.ir, x.ir);
               if (x.ndreq > 0) chk("dmem_we", 32'(lwe), 32'(x.we));
               m_instret = m_instret + 1'b1;
            end
            @(posedge CLK);
            #1;
            chk("instret", 32'(bus.instret), 32'(m_instret));
         end
         if (!done) @(posedge CLK);
         @(negedge CLK);
      end
      if (!done) chk("retire_budget", 32'd0, 32'd1);
      bus.imem_ready = 1'b0;
      bus.dmem_ready = 1'b0;
   endtask

   task automatic run_trap(input logic [31:0] instr, input bit iok, input bit dok,
                           input logic [1:0] cause, input int nireq, input int ndreq);
      int ni = 0, nd = 0;
      bit hit = 1'b0, bad = 1'b0, bad2 = 1'b0;
      bus.imem_rdata = instr;
      {bus.alu_zero, bus.alu_lt, bus.alu_ltu} = 3'b000;
      for (int k = 0; k < 30 && !hit; k++) begin
         bus.imem_ready = bus.imem_req && iok;
         bus.dmem_ready = bus.dmem_req && dok;
         #1;
         if (bus.imem_req) ni++;
         if (bus.dmem_req) nd++;
         if (bus.pc_write || bus.reg_write) bad = 1'b1;
         if (bus.trap) hit = 1'b1;
         else begin
            @(posedge CLK);
            @(negedge CLK);
         end
      end
      chk("trap_reached", 32'(hit), 32'd1);
      chk("trap_cause", 32'(bus.trap_cause), 32'(cause));
      chk("imem_req_cycles", 32'(ni), 32'(nireq));
      chk("dmem_req_cycles", 32'(nd), 32'(ndreq));
      chk("no_enable_before_trap", 32'(bad), 32'd0);
      bus.imem_ready = 1'b1;
      bus.dmem_ready = 1'b1;
      repeat (5) begin
         @(negedge CLK);
         #1;
         if (bus.imem_req || bus.dmem_req || bus.pc_write || bus.reg_write || !bus.trap
             || bus.trap_cause !== cause) bad2 = 1'b1;
      end
      chk("trap_sticky", 32'(bad2), 32'd0);
      chk("trap_instret", 32'(bus.instret), 32'(m_instret));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired checks=%0d", checks);
      $fatal(1);
   end

   initial begin
      bus.imem_rdata = '0;
      bus.imem_ready = 1'b0;
      bus.dmem_ready = 1'b0;
      {bus.alu_zero, bus.alu_lt, bus.alu_ltu} = 3'b000;
      //                instr         flg   iw dw cyc rw  wb     pcs    nd we  op      sa     sb
      vecs.push_back(vec_t'{32'h002081B3, 3'b000, 0, 0, 4, 1'b1, 2'b00, 2'b00, 0, 1'b0, 3'b000, 2'b00, 2'b00});
      vecs.push_back(vec_t'{32'h00500093, 3'b000, 0, 0, 4, 1'b1, 2'b00, 2'b00, 0, 1'b0, 3'b001, 2'b00, 2'b01});
      vecs.push_back(vec_t'{32'h0000A183, 3'b000, 0, 3, 8, 1'b1, 2'b01, 2'b00, 4, 1'b0, 3'b010, 2'b00, 2'b01});
      vecs.push_back(vec_t'{32'h0020A023, 3'b000, 0, 0, 4, 1'b0, 2'b00, 2'b00, 1, 1'b1, 3'b010, 2'b00, 2'b01});
      vecs.push_back(vec_t'{32'h00208463, 3'b100, 0, 0, 3, 1'b0, 2'b00, 2'b01, 0, 1'b0, 3'b100, 2'b00, 2'b00});
      vecs.push_back(vec_t'{32'h00208463, 3'b000, 0, 0, 3, 1'b0, 2'b00, 2'b00, 0, 1'b0, 3'b100, 2'b00, 2'b00});
      vecs.push_back(vec_t'{32'h00209463, 3'b000, 0, 0, 3, 1'b0, 2'b00, 2'b01, 0, 1'b0, 3'b100, 2'b00, 2'b00});
      vecs.push_back(vec_t'{32'h0020C463, 3'b010, 0, 0, 3, 1'b0, 2'b00, 2'b01, 0, 1'b0, 3'b100, 2'b00, 2'b00});
      vecs.push_back(vec_t'{32'h0020D463, 3'b010, 0, 0, 3, 1'b0, 2'b00, 2'b00, 0, 1'b0, 3'b100, 2'b00, 2'b00});
      vecs.push_back(vec_t'{32'h0020E463, 3'b000, 0, 0, 3, 1'b0, 2'b00, 2'b00, 0, 1'b0, 3'b100, 2'b00, 2'b00});
      vecs.push_back(vec_t'{32'h0020F463, 3'b000, 0, 0, 3, 1'b0, 2'b00, 2'b01, 0, 1'b0, 3'b100, 2'b00, 2'b00});
      vecs.push_back(vec_t'{32'h008000EF, 3'b000, 0, 0, 4, 1'b1, 2'b10, 2'b01, 0, 1'b0, 3'b000, 2'b00, 2'b00});
      vecs.push_back(vec_t'{32'h000080E7, 3'b000, 0, 0, 4, 1'b1, 2'b10, 2'b10, 0, 1'b0, 3'b010, 2'b00, 2'b01});
      vecs.push_back(vec_t'{32'h123450B7, 3'b000, 0, 0, 4, 1'b1, 2'b11, 2'b00, 0, 1'b0, 3'b000, 2'b00, 2'b00});
      vecs.push_back(vec_t'{32'h00001097, 3'b000, 0, 0, 4, 1'b1, 2'b00, 2'b00, 0, 1'b0, 3'b010, 2'b01, 2'b01});
      vecs.push_back(vec_t'{32'h002081B3, 3'b000, 2, 0, 6, 1'b1, 2'b00, 2'b00, 0, 1'b0, 3'b000, 2'b00, 2'b00});
      vecs.push_back(vec_t'{32'h002081B3, 3'b000, 3, 0, 7, 1'b1, 2'b00, 2'b00, 0, 1'b0, 3'b000, 2'b00, 2'b00});
      vecs.push_back(vec_t'{32'h0020A023, 3'b000, 0, 3, 7, 1'b0, 2'b00, 2'b00, 4, 1'b1, 3'b010, 2'b00, 2'b01});

      do_reset();
      // Two passes push instret past 2^CNT_W so the wrap is exercised.
      for (int p = 0; p < 2; p++)
         foreach (vecs[i]) run_vec(vecs[i]);
      chk("sb_drained", 32'(sbq.size()), 32'd0);

      // Reset asserted during WB must drop all enables at once.
      do_reset();
      run_vec(vecs[0]);
      bus.imem_rdata = 32'h002081B3;
      bus.imem_ready = 1'b1;
      #1;
      repeat (3) @(negedge CLK);
      #1;
      chk("wb_before_reset", 32'({bus.reg_write, bus.pc_write}), 32'b11);
      RST = 1'b1;
      #1;
      chk("mid_reset_outs", 32'({bus.reg_write, bus.pc_write, bus.imem_req, bus.dmem_req}), 32'd0);
      chk("mid_reset_instret", 32'(bus.instret), 32'd0);
      @(posedge CLK);
      #1;
      chk("mid_reset_hold", 32'({bus.reg_write, bus.pc_write, bus.imem_req, bus.instret}), 32'd0);

      do_reset();
      run_trap(32'h0000007F, 1'b1, 1'b1, 2'b01, 1, 0);
      do_reset();
      run_trap(32'h0020A463, 1'b1, 1'b1, 2'b01, 1, 0);
      do_reset();
      run_trap(32'h002081B3, 1'b0, 1'b1, 2'b10, TIMEOUT, 0);
      do_reset();
      run_trap(32'h0000A183, 1'b1, 1'b0, 2'b11, 1, TIMEOUT);
      do_reset();
      chk("trap_cleared", 32'({bus.trap, bus.trap_cause}), 32'd0);
      run_vec(vecs[12]);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
